// File: rtl/sec_a2b_goubin.sv
// First-order arithmetic-to-Boolean mask conversion (Goubin).
// Converts shares (A, r) with x = A + r mod 2^K into (x', r) with x = x' ^ r,
// one carry-propagation iteration per enabled cycle, never forming x itself.
module sec_a2b_goubin #(
   parameter int unsigned K_WIDTH  = 32,
   parameter int unsigned N_SHARES = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   dvld,
   input  logic                   ena,
   input  logic [K_WIDTH-1:0]     rnd,
   input  logic [2*K_WIDTH-1:0]   i_a,
   output logic [2*K_WIDTH-1:0]   o_b,
   output logic                   ovld,
   output logic                   busy
);

   localparam int unsigned KW = K_WIDTH;
   localparam int unsigned CW = (K_WIDTH > 1) ? $clog2(K_WIDTH) : 1;

   // Only the first-order (two-share) scheme is implemented
   if (N_SHARES != 2) begin : g_bad_shares
      $error("sec_a2b_goubin: N_SHARES must be 2");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      INIT = 2'd1,
      LOOP = 2'd2,
      FIN  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [KW-1:0]       a_q, a_d;
   logic [KW-1:0]       r_q, r_d;
   logic [KW-1:0]       gamma_q, gamma_d;
   logic [KW-1:0]       t_q, t_d;
   logic [KW-1:0]       xp_q, xp_d;
   logic [KW-1:0]       omega_q, omega_d;
   logic [2*KW-1:0]     ob_d;
   logic                ovld_d;
   logic                busy_d;

   // Masked intermediates of the setup sequence and one loop iteration
   logic [KW-1:0]       t_init;
   logic [KW-1:0]       xp_init;
   logic [KW-1:0]       om_init;
   logic [KW-1:0]       g_mix;
   logic [KW-1:0]       g_init;
   logic [KW-1:0]       g_loop;

   // State register and datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         r_q     <= '0;
         gamma_q <= '0;
         t_q     <= '0;
         xp_q    <= '0;
         omega_q <= '0;
         o_b     <= '0;
         ovld    <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         r_q     <= r_d;
         gamma_q <= gamma_d;
         t_q     <= t_d;
         xp_q    <= xp_d;
         omega_q <= omega_d;
         o_b     <= ob_d;
         ovld    <= ovld_d;
         busy    <= busy_d;
      end
   end

   // Next-state, datapath and output decode; ena low holds everything
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      r_d     = r_q;
      gamma_d = gamma_q;
      t_d     = t_q;
      xp_d    = xp_q;
      omega_d = omega_q;
      ob_d    = o_b;
      ovld_d  = 1'b0;

      // Setup sequence collapsed into one update; every term stays masked by gamma or r
      t_init  = KW'(gamma_q << 1);
      xp_init = gamma_q ^ r_q;
      om_init = gamma_q & xp_init;
      xp_init = t_init ^ a_q;
      g_mix   = (gamma_q ^ xp_init) & r_q;
      om_init = om_init ^ g_mix;
      g_init  = t_init & a_q;
      om_init = om_init ^ g_init;

      // One carry-propagation step
      g_loop  = (t_q & r_q) ^ omega_q ^ (t_q & a_q);

      if (ena) begin
         case (state_q)
            IDLE: begin
               if (dvld) begin
                  a_d     = i_a[0 +: KW];
                  r_d     = i_a[KW +: KW];
                  gamma_d = rnd;
                  state_d = INIT;
               end
            end
            INIT: begin
               t_d     = t_init;
               xp_d    = xp_init;
               omega_d = om_init;
               gamma_d = g_init;
               cnt_d   = CW'(1);
               state_d = LOOP;
            end
            LOOP: begin
               gamma_d = g_loop;
               t_d     = KW'(g_loop << 1);
               cnt_d   = cnt_q + CW'(1);
               if (cnt_q == CW'(KW - 1)) begin
                  state_d = FIN;
               end
            end
            FIN: begin
               ob_d    = {r_q, xp_q ^ t_q};
               ovld_d  = 1'b1;
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      busy_d = (state_d != IDLE);
   end

endmodule

// File: tb/tb_sec_a2b_goubin.sv
// Self-checking bench for sec_a2b_goubin: transaction-level model plus directed cases.
module tb_sec_a2b_goubin;

   localparam int unsigned K = 32;

   logic            clk;
   logic            rst_n;
   logic            dvld;
   logic            ena;
   logic [K-1:0]    rnd;
   logic [2*K-1:0]  i_a;
   logic [2*K-1:0]  o_b;
   logic            ovld;
   logic            busy;

   int total = 0;
   int bad   = 0;

   sec_a2b_goubin #(.K_WIDTH(K), .N_SHARES(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .dvld  (dvld),
      .ena   (ena),
      .rnd   (rnd),
      .i_a   (i_a),
      .o_b   (o_b),
      .ovld  (ovld),
      .busy  (busy)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
      end
   endtask

   // Transaction-level model: one job in flight, done after K+1 enabled edges
   logic [K-1:0]    ma, mr;
   int              en_cnt;
   bit              inflight;
   bit              exp_ovld;
   logic [63:0]     hold;
   bit              started;

   always @(posedge clk) begin
      started  <= 1'b1;
      exp_ovld <= 1'b0;
      if (!rst_n) begin
         inflight <= 1'b0;
         en_cnt   <= 0;
         hold     <= '0;
      end else if (inflight) begin
         if (ena) begin
            if (en_cnt == int'(K)) begin
               inflight <= 1'b0;
               exp_ovld <= 1'b1;
               hold     <= {mr, (ma + mr) ^ mr};
            end else begin
               en_cnt <= en_cnt + 1;
            end
         end
      end else if (dvld && ena) begin
         inflight <= 1'b1;
         en_cnt   <= 0;
         ma       <= i_a[0 +: K];
         mr       <= i_a[K +: K];
      end
   end

   // Compare process: outputs against the model on every cycle
   always @(negedge clk) begin
      if (started) begin
         check("cyc_ovld", 64'(ovld), 64'(exp_ovld));
         check("cyc_busy", 64'(busy), 64'(inflight));
         check("cyc_ob", o_b, hold);
      end
   end

   // One transaction with optional stall window, dvld pokes, reset hit or random ena
   task automatic run_txn(input logic [31:0] a, input logic [31:0] r, input logic [31:0] g,
                          input int stall_at, input int stall_len, input int dv1, input int dv2,
                          input int rst_at, input bit rand_ena,
                          output logic [63:0] ob, output int lat);
      int w;
      bit done;
      ob = '0;
      lat = -1;
      w = 0;
      while (busy !== 1'b0 && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (busy !== 1'b0) begin
         total++;
         bad++;
         $display("FAIL idle_wait: busy=%b required 0", busy);
         return;
      end
      i_a  = {r, a};
      rnd  = g;
      dvld = 1'b1;
      ena  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      dvld = 1'b0;
      rnd  = $urandom;
      done = 1'b0;
      for (int n = 1; n <= 300 && !done; n++) begin
         ena = 1'b1;
         if (rand_ena) ena = ($urandom_range(3) != 0);
         if (stall_len > 0 && n > stall_at && n <= stall_at + stall_len) ena = 1'b0;
         dvld = (n == dv1 || n == dv2);
         if (dvld) i_a = {$urandom, $urandom};
         rst_n = !(rst_at >= 0 && n == rst_at + 1);
         @(posedge clk);
         @(negedge clk);
         dvld = 1'b0;
         if (!rst_n) begin
            rst_n = 1'b1;
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_ovld", 64'(ovld), 64'd0);
            check("rst_ob", o_b, 64'd0);
            for (int m = 0; m < 40; m++) begin
               ena = 1'b1;
               @(posedge clk);
               @(negedge clk);
               check("rst_no_ovld", 64'(ovld), 64'd0);
            end
            done = 1'b1;
         end else if (ovld) begin
            ob   = o_b;
            lat  = n + 1;
            done = 1'b1;
         end
      end
      ena = 1'b1;
      if (!done) begin
         total++;
         bad++;
         $display("FAIL ovld_timeout: no ovld within 300 cycles, required one");
      end
   endtask

   // Watchdog
   initial begin
      #20ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] ob, ob2, ref1;
      int          lat;
      logic [31:0] a, r;

      rst_n = 1'b0;
      dvld  = 1'b0;
      ena   = 1'b0;
      rnd   = '0;
      i_a   = '0;
      repeat (3) @(negedge clk);
      check("reset_ob", o_b, 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_ovld", 64'(ovld), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic conversion: 5 + 3 = 8, 8 ^ 3 = 0xB
      run_txn(32'h5, 32'h3, 32'hDEADBEEF, -1, 0, -1, -1, -1, 1'b0, ob, lat);
      check("basic_ob", ob, 64'h00000003_0000000B);
      check("basic_lat", 64'(lat), 64'd34);
      ref1 = ob;

      // Wraparound, issued back-to-back
      run_txn(32'hFFFFFFFF, 32'h1, $urandom, -1, 0, -1, -1, -1, 1'b0, ob, lat);
      check("wrap_ob", ob, 64'h00000001_00000001);
      check("wrap_lat", 64'(lat), 64'd34);

      // Same shares, different randomness
      run_txn(32'h5, 32'h3, 32'h12345678, -1, 0, -1, -1, -1, 1'b0, ob, lat);
      check("rnd_indep_ob", ob, ref1);

      // Five-cycle stall once the counter reads 10
      run_txn(32'h5, 32'h3, $urandom, 10, 5, -1, -1, -1, 1'b0, ob, lat);
      check("stall_ob", ob, 64'h00000003_0000000B);
      check("stall_lat", 64'(lat), 64'd39);

      // dvld while busy is ignored
      run_txn(32'h5, 32'h3, $urandom, -1, 0, 5, 20, -1, 1'b0, ob, lat);
      check("dvld_busy_ob", ob, 64'h00000003_0000000B);
      check("dvld_busy_lat", 64'(lat), 64'd34);

      // Reset in the middle of the loop
      run_txn(32'h1234, 32'h5678, $urandom, -1, 0, -1, -1, 12, 1'b0, ob, lat);

      // First job after reset: 0x10 + 0x20 = 0x30, 0x30 ^ 0x20 = 0x10
      run_txn(32'h10, 32'h20, $urandom, -1, 0, -1, -1, -1, 1'b0, ob, lat);
      check("post_rst_ob", ob, 64'h00000020_00000010);
      check("post_rst_lat", 64'(lat), 64'd34);

      // Random pairs: same shares, two random masks, random ena gaps
      for (int i = 0; i < 500; i++) begin
         a = $urandom;
         r = $urandom;
         run_txn(a, r, $urandom, -1, 0, -1, -1, -1, 1'b1, ob, lat);
         check("rand_ob", ob, {r, (a + r) ^ r});
         run_txn(a, r, $urandom, -1, 0, -1, -1, -1, 1'b1, ob2, lat);
         check("rand_pair_ob", ob2, ob);
         repeat ($urandom_range(2)) begin
            ena = ($urandom_range(1) != 0);
            @(negedge clk);
         end
         ena = 1'b1;
      end

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
